// File: rtl/palette_loader.sv
// rtl/palette_loader.sv - streams colour words into a palette RAM with 1-cycle registered writes.
// Optional readback checksum verify compiled in with PALETTE_LOADER_VERIFY_EN.
module palette_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] startAddr,
    input  logic [ADDR_W:0]   count,
    input  logic              inValid,
    input  logic [DATA_W-1:0] inData,
    output logic              inReady,
    output logic              palWriteEn,
    output logic [ADDR_W-1:0] palAddr,
    output logic [DATA_W-1:0] palWriteData,
    input  logic [DATA_W-1:0] palReadData,
    output logic              busy,
    output logic              done,
    output logic              error
);
`ifdef PALETTE_LOADER_VERIFY_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_VERIFY = 2'd2, S_FIN = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_FIN = 2'd3} state_t;
`endif

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ZERO = '0;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic              pal_we_q, pal_we_d;
    logic [ADDR_W-1:0] pal_addr_q, pal_addr_d;
    logic [DATA_W-1:0] pal_wdata_q, pal_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              beat;

`ifdef PALETTE_LOADER_VERIFY_EN
    logic [ADDR_W-1:0] start_addr_q, start_addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] verify_addr_q, verify_addr_d;
    logic [ADDR_W:0]   verify_left_q, verify_left_d;
    logic [15:0]       sum_wr_q, sum_wr_d;
    logic [15:0]       sum_rd_q, sum_rd_d;
    logic              error_q, error_d;
    logic [15:0]       in16, rd16, rd_sum;

    assign in16    = 16'(inData);
    assign rd16    = 16'(palReadData);
    assign rd_sum  = sum_rd_q + rd16;
    assign error   = error_q;
    assign palAddr = (state_q == S_VERIFY) ? verify_addr_q : pal_addr_q;
`else
    logic unused_rd;

    assign unused_rd = ^palReadData;
    assign error     = 1'b0;
    assign palAddr   = pal_addr_q;
`endif

    assign inReady      = (state_q == S_LOAD) && (remaining_q != CNT_ZERO);
    assign beat         = inValid && inReady;
    assign palWriteEn   = pal_we_q;
    assign palWriteData = pal_wdata_q;
    assign busy         = busy_q;
    assign done         = done_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        pal_we_d    = 1'b0;
        pal_addr_d  = pal_addr_q;
        pal_wdata_d = pal_wdata_q;
        // busy/done are registered views of the state, so done follows FIN by one cycle
        busy_d      = (state_q != S_IDLE);
        done_d      = (state_q == S_FIN);
`ifdef PALETTE_LOADER_VERIFY_EN
        start_addr_d  = start_addr_q;
        count_d       = count_q;
        verify_addr_d = verify_addr_q;
        verify_left_d = verify_left_q;
        sum_wr_d      = sum_wr_q;
        sum_rd_d      = sum_rd_q;
        error_d       = error_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef PALETTE_LOADER_VERIFY_EN
                    error_d = 1'b0;
`endif
                    if (count != CNT_ZERO) begin
                        addr_d      = startAddr;
                        remaining_d = count;
                        state_d     = S_LOAD;
`ifdef PALETTE_LOADER_VERIFY_EN
                        start_addr_d = startAddr;
                        count_d      = count;
                        sum_wr_d     = '0;
`endif
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_LOAD: begin
                if (beat) begin
                    pal_we_d    = 1'b1;
                    pal_addr_d  = addr_q;
                    pal_wdata_d = inData;
                    addr_d      = addr_q + ADDR_ONE;
                    remaining_d = remaining_q - CNT_ONE;
`ifdef PALETTE_LOADER_VERIFY_EN
                    sum_wr_d    = sum_wr_q + in16;
`else
                    if (remaining_q == CNT_ONE) begin
                        state_d = S_FIN;
                    end
`endif
                end
`ifdef PALETTE_LOADER_VERIFY_EN
                // wait one cycle after the last beat so the final write lands before readback
                if (remaining_q == CNT_ZERO) begin
                    state_d       = S_VERIFY;
                    verify_addr_d = start_addr_q;
                    verify_left_d = count_q;
                    sum_rd_d      = '0;
                end
`endif
            end
`ifdef PALETTE_LOADER_VERIFY_EN
            S_VERIFY: begin
                sum_rd_d      = rd_sum;
                verify_addr_d = verify_addr_q + ADDR_ONE;
                verify_left_d = verify_left_q - CNT_ONE;
                if (verify_left_q == CNT_ONE) begin
                    error_d = (rd_sum != sum_wr_q);
                    state_d = S_FIN;
                end
            end
`endif
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            pal_we_q    <= 1'b0;
            pal_addr_q  <= '0;
            pal_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef PALETTE_LOADER_VERIFY_EN
            start_addr_q  <= '0;
            count_q       <= '0;
            verify_addr_q <= '0;
            verify_left_q <= '0;
            sum_wr_q      <= '0;
            sum_rd_q      <= '0;
            error_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            pal_we_q    <= pal_we_d;
            pal_addr_q  <= pal_addr_d;
            pal_wdata_q <= pal_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef PALETTE_LOADER_VERIFY_EN
            start_addr_q  <= start_addr_d;
            count_q       <= count_d;
            verify_addr_q <= verify_addr_d;
            verify_left_q <= verify_left_d;
            sum_wr_q      <= sum_wr_d;
            sum_rd_q      <= sum_rd_d;
            error_q       <= error_d;
`endif
        end
    end

endmodule

// File: tb/tb_palette_loader.sv
// tb/tb_palette_loader.sv - scoreboard bench for palette_loader with a palette RAM model.
module tb_palette_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  startAddr;
    logic [10:0] count;
    logic        inValid;
    logic [15:0] inData;
    logic        inReady;
    logic        palWriteEn;
    logic [9:0]  palAddr;
    logic [15:0] palWriteData;
    logic [15:0] palReadData;
    logic        busy;
    logic        done;
    logic        error;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    wr_t  exp_wr[$];
    int   exp_cyc[$];
    wr_t  mon_e;
    logic [15:0] mem [1024];
    bit   corrupt_en = 1'b0;
    int   corrupt_addr = 0;

    palette_loader #(.ADDR_W(10), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .startAddr(startAddr), .count(count),
        .inValid(inValid), .inData(inData), .inReady(inReady),
        .palWriteEn(palWriteEn), .palAddr(palAddr), .palWriteData(palWriteData),
        .palReadData(palReadData), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign palReadData = mem[palAddr];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every palette write is popped against the scoreboard and mirrored into the RAM model
    always @(negedge clk) begin
        if (palWriteEn === 1'b1) begin
            if (exp_wr.size() == 0) begin
                chk("unexpected_write", int'(palAddr), -1);
            end else begin
                mon_e = exp_wr.pop_front();
                chk("wr_addr", int'(palAddr), mon_e.addr);
                chk("wr_data", int'(palWriteData), mon_e.data);
                if (exp_cyc.size() == 0) chk("wr_without_beat", cyc, -1);
                else chk("wr_cycle", cyc, exp_cyc.pop_front());
            end
            if (corrupt_en && int'(palAddr) == corrupt_addr) mem[palAddr] = palWriteData ^ 16'h0001;
            else mem[palAddr] = palWriteData;
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_inReady"}, int'(inReady), 0);
        chk({tag, "_palWriteEn"}, int'(palWriteEn), 0);
        chk({tag, "_palAddr"}, int'(palAddr), 0);
        chk({tag, "_palWriteData"}, int'(palWriteData), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_error"}, int'(error), 0);
    endtask

    // mode 0: continuous valid, 1: random valid, 2: valid on even cycles
    task automatic run_load(input int sa, input int cnt, input int mode, input bit fixed, input bit exp_err);
        logic [15:0] dat[$];
        wr_t w;
        int sent, t, start_c, pulses;
        bit v;
        for (int i = 0; i < cnt; i++) begin
            dat.push_back(fixed ? 16'((i + 1) * 'h1111) : 16'($urandom));
            w.addr = (sa + i) % 1024;
            w.data = int'(dat[i]);
            exp_wr.push_back(w);
        end
        start = 1'b1; startAddr = 10'(sa); count = 11'(cnt); start_c = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("error_cleared_by_start", int'(error), 0);
        sent = 0; t = 0;
        while (sent < cnt && t < 4 * cnt + 50) begin
            case (mode)
                0: v = 1'b1;
                1: v = 1'($urandom_range(0, 1));
                default: v = (t % 2 == 0);
            endcase
            inValid = v;
            inData = v ? dat[sent] : 16'($urandom);
            if (v && inReady) begin
                exp_cyc.push_back(cyc + 1);
                sent++;
            end
            @(negedge clk);
            t++;
        end
        chk("all_beats_accepted", sent, cnt);
        inValid = 1'b0;
        if (cnt > 0) chk("inReady_drop_after_last", int'(inReady), 0);
        t = 0;
        while (done !== 1'b1 && t < 2 * cnt + 20) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", int'(done), 1);
        if (cnt == 0) chk("done_latency_count0", cyc - start_c, 2);
        chk("error_at_done", int'(error), int'(exp_err));
        chk("busy_at_done", int'(busy), 1);
        @(negedge clk);
        chk("busy_after_done", int'(busy), 0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            pulses += int'(done);
            @(negedge clk);
        end
        chk("done_single_pulse", pulses, 0);
        chk("error_held", int'(error), int'(exp_err));
        chk("writes_outstanding", exp_wr.size(), 0);
    endtask

    task automatic reset_mid_load(input int sa);
        logic [15:0] dat[$];
        wr_t w;
        for (int i = 0; i < 5; i++) dat.push_back(16'($urandom));
        for (int i = 0; i < 2; i++) begin
            w.addr = (sa + i) % 1024;
            w.data = int'(dat[i]);
            exp_wr.push_back(w);
        end
        start = 1'b1; startAddr = 10'(sa); count = 11'd5;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            inValid = 1'b1; inData = dat[i];
            chk("ready_before_reset", int'(inReady), 1);
            exp_cyc.push_back(cyc + 1);
            @(negedge clk);
        end
        inValid = 1'b1; inData = dat[2]; rst = 1'b1; start = 1'b1;
        @(negedge clk);
        check_all_zero("after_midload_rst");
        rst = 1'b0; inValid = 1'b0; start = 1'b0;
        repeat (4) @(negedge clk);
        chk("writes_after_abort", exp_wr.size(), 0);
        chk("beats_after_abort", exp_cyc.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        rst = 1'b1; start = 1'b0; startAddr = '0; count = '0; inValid = 1'b0; inData = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        run_load(5, 3, 0, 1'b1, 1'b0);
        run_load(1022, 4, 0, 1'b0, 1'b0);
        run_load(100, 3, 2, 1'b0, 1'b0);
        run_load(7, 0, 0, 1'b0, 1'b0);
        reset_mid_load(300);
        run_load(300, 5, 0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            run_load(int'($urandom_range(0, 1023)), int'($urandom_range(1, 20)), 1, 1'b0, 1'b0);
        end
        run_load(int'($urandom_range(0, 1023)), 1024, 0, 1'b0, 1'b0);
`ifdef PALETTE_LOADER_VERIFY_EN
        corrupt_en = 1'b1;
        corrupt_addr = 1023;
        run_load(1021, 4, 0, 1'b0, 1'b1);
        corrupt_en = 1'b0;
        run_load(40, 6, 1, 1'b0, 1'b0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
